// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes and FSM states.
package alu_pkg;

    // Opcode encoding as carried on the S input.
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_ROL = 3'd7
    } op_e;

    // FSM state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // True for opcodes that finish in a single cycle through alu_core.
    function automatic logic is_single_cycle(input logic [2:0] s);
        return s <= OP_XOR;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational datapath for the single-cycle opcodes (add, sub, and, or, xor).
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
    input  logic [2:0]   S,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         overflow
);

    logic [W:0] sum_ext;

    // Select the result and flags for the requested arithmetic/logic op.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        sum_ext  = '0;
        case (op_e'(S))
            OP_ADD: begin
                sum_ext  = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, Cin};
                result   = sum_ext[W-1:0];
                carry    = sum_ext[W];
                // Same-sign operands producing a result of the other sign.
                overflow = (A[W-1] == B[W-1]) && (result[W-1] != A[W-1]);
            end
            OP_SUB: begin
                sum_ext  = {1'b0, A} - {1'b0, B} - {{W{1'b0}}, Cin};
                result   = sum_ext[W-1:0];
                carry    = sum_ext[W];  // borrow
                // Opposite-sign operands where the result leaves A's sign.
                overflow = (A[W-1] != B[W-1]) && (result[W-1] != A[W-1]);
            end
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_XOR:  result = A ^ B;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: one-cycle arithmetic/logic ops, and shift/rotate ops that
// move one bit position per cycle on an internal register.
module seq_alu
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
    input  logic [2:0]   S,
    output logic [W-1:0] O,
    output logic         Cout,
    output logic         Z,
    output logic         V,
    output logic         busy,
    output logic         done
);

    localparam int SW = $clog2(W);

    state_e        state;
    logic [W-1:0]  shreg;
    logic [SW-1:0] count;
    op_e           shop;

    logic [W-1:0]  core_result;
    logic          core_carry;
    logic          core_overflow;

    logic [SW-1:0] shamt;
    logic [W-1:0]  step_val;
    logic          step_out;

    assign shamt = B[SW-1:0];

    alu_core #(.W(W)) u_core (
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .S        (S),
        .result   (core_result),
        .carry    (core_carry),
        .overflow (core_overflow)
    );

    // One bit-position step of the active shift/rotate and the bit it exposes.
    // For rol the exposed bit is the new LSB, so the final step yields O[0].
    always_comb begin
        step_val = shreg;
        step_out = 1'b0;
        case (shop)
            OP_SHL: begin
                step_val = {shreg[W-2:0], 1'b0};
                step_out = shreg[W-1];
            end
            OP_SHR: begin
                step_val = {1'b0, shreg[W-1:1]};
                step_out = shreg[0];
            end
            OP_ROL: begin
                step_val = {shreg[W-2:0], shreg[W-1]};
                step_out = shreg[W-1];
            end
            default: begin
                step_val = shreg;
                step_out = 1'b0;
            end
        endcase
    end

    // Control FSM with registered result, flags, busy and done.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            state <= ST_IDLE;
            O     <= '0;
            Cout  <= 1'b0;
            Z     <= 1'b0;
            V     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            count <= '0;
            // NOTE: the shift register is cleared too; it is only a few flops
            // and a known value keeps the datapath deterministic after reset.
            shreg <= '0;
            shop  <= OP_SHL;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (is_single_cycle(S)) begin
                            O     <= core_result;
                            Cout  <= core_carry;
                            V     <= core_overflow;
                            Z     <= (core_result == '0);
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (shamt == '0) begin
                            O     <= A;
                            Cout  <= 1'b0;
                            V     <= 1'b0;
                            Z     <= (A == '0);
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            shreg <= A;
                            count <= shamt;
                            shop  <= op_e'(S);
                            state <= ST_SHIFT;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    shreg <= step_val;
                    count <= count - 1'b1;
                    if (count == SW'(1)) begin
                        O     <= step_val;
                        Cout  <= step_out;
                        V     <= 1'b0;
                        Z     <= (step_val == '0);
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (W=8): directed cases plus random operations
// compared against an arithmetic reference model.
module tb_seq_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A, B;
    logic         Cin;
    logic [2:0]   S;
    logic [W-1:0] O;
    logic         Cout, Z, V, busy, done;

    int n_checks = 0;
    int n_errors = 0;

    seq_alu #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .S     (S),
        .O     (O),
        .Cout  (Cout),
        .Z     (Z),
        .V     (V),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model from the arithmetic definition of each opcode.
    task automatic model(input logic [2:0] s, input int a, input int b, input int cin,
                         output int o, output int c, output int z, output int v,
                         output int lat);
        int n, r, sa, sb, sr;
        n   = b % W;
        c   = 0;
        v   = 0;
        lat = 1;
        sa  = (a >= 128) ? a - 256 : a;
        sb  = (b >= 128) ? b - 256 : b;
        case (s)
            3'd0: begin
                r = a + b + cin;  o = r % 256;  c = r / 256;
                sr = sa + sb + cin;  v = (sr > 127 || sr < -128) ? 1 : 0;
            end
            3'd1: begin
                r = a - b - cin;  c = (r < 0) ? 1 : 0;  o = (r + 512) % 256;
                sr = sa - sb - cin;  v = (sr > 127 || sr < -128) ? 1 : 0;
            end
            3'd2: o = a & b;
            3'd3: o = a | b;
            3'd4: o = a ^ b;
            default: begin
                if (n == 0) begin
                    o = a;
                end else begin
                    lat = n + 1;
                    if (s == 3'd5) begin
                        o = (a << n) % 256;  c = (a >> (W - n)) & 1;
                    end else if (s == 3'd6) begin
                        o = a >> n;  c = (a >> (n - 1)) & 1;
                    end else begin
                        o = ((a << n) | (a >> (W - n))) % 256;  c = o & 1;
                    end
                end
            end
        endcase
        z = (o == 0) ? 1 : 0;
    endtask

    // Issue one operation (called #1 after an edge) and check its outcome.
    // With poke set, a competing start (S=2) is raised during the first busy cycle.
    task automatic run_op(input string tag, input logic [2:0] s, input logic [7:0] a,
                          input logic [7:0] b, input logic cin, input bit poke);
        int eo, ec, ez, ev, elat, cycles;
        logic [W-1:0] prev_o;
        model(s, int'(a), int'(b), int'(cin), eo, ec, ez, ev, elat);
        prev_o = O;
        S = s;  A = a;  B = b;  Cin = cin;  start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cycles = 1;
        while (!done && cycles < 40) begin
            check({tag, "_busy"}, busy, 1);
            check({tag, "_hold"}, O, prev_o);
            if (poke && cycles == 1) begin
                S = 3'd2;  A = 8'hFF;  B = 8'hFF;  start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_lat"}, cycles, elat);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_O"}, O, eo);
        check({tag, "_Cout"}, Cout, ec);
        check({tag, "_Z"}, Z, ez);
        check({tag, "_V"}, V, ev);
    endtask

    task automatic idle_cycle(input string tag);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, "_done_low"}, done, 0);
        check({tag, "_busy_low"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1;  start = 1'b0;  A = '0;  B = '0;  Cin = 1'b0;  S = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_O", O, 0);
        check("rst_flags", {Cout, Z, V}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        run_op("add_wrap", 3'd0, 8'hFF, 8'h01, 1'b0, 0);
        idle_cycle("add_wrap");
        run_op("sub_ovf", 3'd1, 8'h80, 8'h01, 1'b0, 0);
        idle_cycle("sub_ovf");
        run_op("shl3", 3'd5, 8'h81, 8'h03, 1'b0, 0);
        idle_cycle("shl3");
        run_op("rol0", 3'd7, 8'h81, 8'h00, 1'b0, 0);
        idle_cycle("rol0");
        run_op("ignore_start", 3'd6, 8'hB5, 8'h05, 1'b0, 1);
        idle_cycle("ignore_start");

        // Back-to-back single-cycle ops, one result per cycle.
        run_op("b2b_add", 3'd0, 8'h7F, 8'h00, 1'b1, 0);
        run_op("b2b_and", 3'd2, 8'hF0, 8'h3C, 1'b0, 0);
        run_op("b2b_sub", 3'd1, 8'h00, 8'h00, 1'b1, 0);
        run_op("b2b_xor", 3'd4, 8'hAA, 8'hAA, 1'b0, 0);
        idle_cycle("b2b");

        // Reset during the second SHIFT cycle, with a start raised alongside.
        S = 3'd6;  A = 8'hF0;  B = 8'h04;  Cin = 1'b0;  start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_busy_before", busy, 1);
        rst = 1'b1;  S = 3'd0;  A = 8'h01;  B = 8'h01;  start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;  start = 1'b0;
        check("rst_mid_O", O, 0);
        check("rst_mid_flags", {Cout, Z, V}, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        idle_cycle("rst_mid_after");
        idle_cycle("rst_mid_after2");
        run_op("post_rst_add", 3'd0, 8'h12, 8'h34, 1'b1, 0);
        idle_cycle("post_rst_add");

        // Random operations, sometimes back-to-back, sometimes with a gap.
        for (int i = 0; i < 300; i++) begin
            run_op("rand", 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                   1'($urandom), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 2) == 0) idle_cycle("rand_gap");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter: W, default 8, operand/result width; W a power of two, W >= 4.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin the operation on A, B, Cin, S.
REQ-005 SHALL have ports: A, B  input  W  operands.
REQ-006 SHALL have port: Cin  input  1  carry/borrow in, used only by add and sub.
REQ-007 SHALL have port: S  input  3  opcode: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 rol.
REQ-008 SHALL have port: O  output  W  registered result.
REQ-009 SHALL have ports: Cout, Z, V  output  1 each  registered carry, zero and signed-overflow flags.
REQ-010 SHALL have port: busy  output  1  high while a shift/rotate operation is in progress.
REQ-011 SHALL have port: done  output  1  one-cycle pulse when O and the flags take a new result.

Function
REQ-012 SHALL sample start, A, B, Cin and S only on an edge where busy=0 (state IDLE or DONE); start with busy=1 SHALL be ignored and not queued.
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE: IDLE/DONE+start with S<=4 -> DONE; IDLE/DONE+start with S>=5 and shamt>0 -> SHIFT; IDLE/DONE+start with S>=5 and shamt=0 -> DONE; SHIFT with count reaching 0 -> DONE; DONE without start -> IDLE.
REQ-014 SHALL form add as {Cout,O} = A+B+Cin and sub as {Cout,O} = A-B-Cin, both computed at W+1 bits, so for sub Cout=1 means borrow.
REQ-015 SHALL set V for add/sub to two's-complement overflow of O relative to the signed operands; V=0 for every other op.
REQ-016 SHALL set O=A&B, A|B or A^B for ops 2-4, with Cout=0.
REQ-017 SHALL take shamt = B[log2(W)-1:0] for ops 5-7 and perform exactly one bit-position shift per SHIFT cycle on an internal register loaded with A.
REQ-018 SHALL set Cout for shl/shr to the last bit shifted out and for rol to the final O[0]; with shamt=0, O=A and Cout=0.
REQ-019 SHALL set Z=1 iff the new O equals 0, for all ops.
REQ-020 SHALL update O, Cout, Z and V only on the edge that enters DONE; they hold their value at all other times, including during SHIFT.
REQ-021 SHALL have latency, from the start-sampling edge to done=1: 1 cycle for ops 0-4 and shift/rotate with shamt=0, and shamt+1 cycles otherwise.
REQ-022 SHALL assert busy exactly while in SHIFT and done exactly while in DONE.
REQ-023 SHALL allow back-to-back operation: a start sampled in DONE begins a new operation on that edge, giving one result per cycle for ops 0-4.

Reset
REQ-024 SHALL, with rst=1 at a rising edge, go to IDLE and clear O, Cout, Z, V, busy, done and the shift counter, with rst taking priority over start.
REQ-025 SHALL, on reset mid-SHIFT, abandon the operation with no done pulse, and produce no result for a start sampled in the same cycle.

Structure
REQ-026 SHALL place the opcode encoding and the FSM state encoding as named constants in shared package alu_pkg.
REQ-027 SHALL implement ops 0-4 in a combinational sub-module alu_core (parameter W; inputs A, B, Cin, S; outputs result, carry, overflow), instantiated once.

Verification (W=8)
REQ-028 SHALL verify: start, S=0, A=0xFF, B=0x01, Cin=0 -> next cycle O=0x00, Cout=1, Z=1, V=0, done=1 for one cycle.
REQ-029 SHALL verify: start, S=1, A=0x80, B=0x01, Cin=0 -> O=0x7F, Cout=0, V=1, Z=0, latency 1.
REQ-030 SHALL verify: start, S=5, A=0x81, B=0x03 -> busy=1 for 3 cycles, O unchanged meanwhile, then O=0x08, Cout=0, done on cycle 4.
REQ-031 SHALL verify: start, S=7, A=0x81, B=0x00 -> 1-cycle latency, O=0x81, Cout=0, busy never asserted.
REQ-032 SHALL verify: a second start (S=2) issued while busy=1 -> ignored, one done only, O equals the shift result.
REQ-033 SHALL verify: rst=1 during the second SHIFT cycle of S=6, A=0xF0, B=0x04 -> next cycle O=0, all flags 0, busy=0, no done, and a later add works normally.
